// File: rtl/reorder_buffer_if.sv
// Issue/writeback/query/commit bundle between issue logic, execution units and the reorder buffer.
// master drives the decoder, writeback and query inputs; slave is the reorder buffer itself.
interface reorder_buffer_if #(
   parameter int ROB_SIZE_WIDTH = 3,
   parameter int XLEN           = 32,
   parameter int REG_CNT_WIDTH  = 5
);
   logic                      stall;
   logic                      dec_ready;
   logic [1:0]                dec_kind;
   logic [REG_CNT_WIDTH-1:0]  dec_rd;
   logic [XLEN-1:0]           dec_pred_pc;

   logic                      alu_ready;
   logic [ROB_SIZE_WIDTH-1:0] alu_rob_id;
   logic [XLEN-1:0]           alu_val;
   logic [XLEN-1:0]           alu_next_pc;

   logic                      lsb_ready;
   logic [ROB_SIZE_WIDTH-1:0] lsb_rob_id;
   logic [XLEN-1:0]           lsb_val;

   logic [ROB_SIZE_WIDTH-1:0] q1_id;
   logic [ROB_SIZE_WIDTH-1:0] q2_id;
   logic                      q1_ready;
   logic                      q2_ready;
   logic [XLEN-1:0]           q1_val;
   logic [XLEN-1:0]           q2_val;

   logic                      rob_full;
   logic [ROB_SIZE_WIDTH-1:0] rob_tail_id;
   logic [ROB_SIZE_WIDTH-1:0] rob_head_id;
   logic                      rob_ready;
   logic [REG_CNT_WIDTH-1:0]  rob_rd;
   logic [XLEN-1:0]           rob_val;
   logic                      rob_store_commit;
   logic                      rob_flush;
   logic [XLEN-1:0]           rob_flush_pc;

   modport master (
      output stall, dec_ready, dec_kind, dec_rd, dec_pred_pc,
      output alu_ready, alu_rob_id, alu_val, alu_next_pc,
      output lsb_ready, lsb_rob_id, lsb_val,
      output q1_id, q2_id,
      input  q1_ready, q2_ready, q1_val, q2_val,
      input  rob_full, rob_tail_id, rob_head_id, rob_ready, rob_rd, rob_val,
      input  rob_store_commit, rob_flush, rob_flush_pc
   );

   modport slave (
      input  stall, dec_ready, dec_kind, dec_rd, dec_pred_pc,
      input  alu_ready, alu_rob_id, alu_val, alu_next_pc,
      input  lsb_ready, lsb_rob_id, lsb_val,
      input  q1_id, q2_id,
      output q1_ready, q2_ready, q1_val, q2_val,
      output rob_full, rob_tail_id, rob_head_id, rob_ready, rob_rd, rob_val,
      output rob_store_commit, rob_flush, rob_flush_pc
   );
endinterface

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: writeback at edge N commits at edge N+1, one entry per cycle.
// Issue is refused while stalled, full or flushing; a mispredicted branch at head empties the buffer.
module reorder_buffer #(
   parameter int ROB_SIZE_WIDTH = 3,
   parameter int XLEN           = 32,
   parameter int REG_CNT_WIDTH  = 5
) (
   input  logic             clk,
   input  logic             rst,
   reorder_buffer_if.slave  bus
);
   localparam int DEPTH = 1 << ROB_SIZE_WIDTH;

   typedef logic [ROB_SIZE_WIDTH-1:0] id_t;
   typedef logic [ROB_SIZE_WIDTH:0]   cnt_t;

   localparam logic [1:0] KIND_REG    = 2'd0;
   localparam logic [1:0] KIND_BRANCH = 2'd1;
   localparam logic [1:0] KIND_STORE  = 2'd2;
   localparam id_t        ID_ONE      = id_t'(1);
   localparam cnt_t       CNT_ONE     = cnt_t'(1);
   localparam cnt_t       CNT_FULL    = cnt_t'(DEPTH);

   logic [DEPTH-1:0]         busy_q;
   logic [DEPTH-1:0]         rdy_q;
   logic [1:0]               kind_q    [DEPTH];
   logic [REG_CNT_WIDTH-1:0] rd_q      [DEPTH];
   logic [XLEN-1:0]          val_q     [DEPTH];
   logic [XLEN-1:0]          pred_pc_q [DEPTH];
   logic [XLEN-1:0]          next_pc_q [DEPTH];

   id_t  head_q;
   id_t  tail_q;
   cnt_t count_q;
   cnt_t count_nxt;

   logic                     full_q;
   logic                     commit_rdy_q;
   logic [REG_CNT_WIDTH-1:0] commit_rd_q;
   logic [XLEN-1:0]          commit_val_q;
   logic                     store_commit_q;
   logic                     flush_q;
   logic [XLEN-1:0]          flush_pc_q;

   logic commit_en;
   logic mispredict;
   logic issue_en;
   logic alu_hit;
   logic lsb_hit;

   // Commit looks only at registered state; a same-cycle writeback to head waits one edge.
   assign commit_en  = busy_q[head_q] && rdy_q[head_q];
   assign mispredict = commit_en && (kind_q[head_q] == KIND_BRANCH)
                       && (next_pc_q[head_q] != pred_pc_q[head_q]);
   assign issue_en   = !bus.stall && bus.dec_ready && !full_q && !flush_q && !mispredict;
   assign alu_hit    = bus.alu_ready && busy_q[bus.alu_rob_id];
   assign lsb_hit    = bus.lsb_ready && busy_q[bus.lsb_rob_id];

   always_comb begin
      count_nxt = count_q;
      if (mispredict) begin
         count_nxt = '0;
      end else if (issue_en && !commit_en) begin
         count_nxt = count_q + CNT_ONE;
      end else if (!issue_en && commit_en) begin
         count_nxt = count_q - CNT_ONE;
      end
   end

   // Operand queries see same-cycle writebacks; LSB takes precedence over ALU on the same id.
   always_comb begin
      bus.q1_ready = busy_q[bus.q1_id] && rdy_q[bus.q1_id];
      bus.q1_val   = val_q[bus.q1_id];
      if (lsb_hit && (bus.lsb_rob_id == bus.q1_id)) begin
         bus.q1_ready = 1'b1;
         bus.q1_val   = bus.lsb_val;
      end else if (alu_hit && (bus.alu_rob_id == bus.q1_id)) begin
         bus.q1_ready = 1'b1;
         bus.q1_val   = bus.alu_val;
      end
   end

   always_comb begin
      bus.q2_ready = busy_q[bus.q2_id] && rdy_q[bus.q2_id];
      bus.q2_val   = val_q[bus.q2_id];
      if (lsb_hit && (bus.lsb_rob_id == bus.q2_id)) begin
         bus.q2_ready = 1'b1;
         bus.q2_val   = bus.lsb_val;
      end else if (alu_hit && (bus.alu_rob_id == bus.q2_id)) begin
         bus.q2_ready = 1'b1;
         bus.q2_val   = bus.alu_val;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q         <= '0;
         rdy_q          <= '0;
         head_q         <= '0;
         tail_q         <= '0;
         count_q        <= '0;
         full_q         <= 1'b0;
         commit_rdy_q   <= 1'b0;
         commit_rd_q    <= '0;
         commit_val_q   <= '0;
         store_commit_q <= 1'b0;
         flush_q        <= 1'b0;
         flush_pc_q     <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            kind_q[i]    <= '0;
            rd_q[i]      <= '0;
            val_q[i]     <= '0;
            pred_pc_q[i] <= '0;
            next_pc_q[i] <= '0;
         end
      end else begin
         count_q        <= count_nxt;
         full_q         <= (count_nxt == CNT_FULL);
         commit_rdy_q   <= 1'b0;
         commit_rd_q    <= '0;
         commit_val_q   <= '0;
         store_commit_q <= 1'b0;
         flush_q        <= 1'b0;
         flush_pc_q     <= '0;

         if (mispredict) begin
            busy_q     <= '0;
            rdy_q      <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            flush_q    <= 1'b1;
            flush_pc_q <= next_pc_q[head_q];
         end else begin
            if (commit_en) begin
               busy_q[head_q] <= 1'b0;
               rdy_q[head_q]  <= 1'b0;
               head_q         <= head_q + ID_ONE;
               case (kind_q[head_q])
                  KIND_REG: begin
                     commit_rdy_q <= 1'b1;
                     commit_rd_q  <= rd_q[head_q];
                     commit_val_q <= val_q[head_q];
                  end
                  KIND_STORE: store_commit_q <= 1'b1;
                  default: ;
               endcase
            end

            if (alu_hit) begin
               val_q[bus.alu_rob_id]     <= bus.alu_val;
               next_pc_q[bus.alu_rob_id] <= bus.alu_next_pc;
               rdy_q[bus.alu_rob_id]     <= 1'b1;
            end
            if (lsb_hit) begin
               val_q[bus.lsb_rob_id] <= bus.lsb_val;
               rdy_q[bus.lsb_rob_id] <= 1'b1;
            end

            if (issue_en) begin
               busy_q[tail_q]    <= 1'b1;
               rdy_q[tail_q]     <= 1'b0;
               kind_q[tail_q]    <= bus.dec_kind;
               rd_q[tail_q]      <= (bus.dec_kind == KIND_REG) ? bus.dec_rd : '0;
               pred_pc_q[tail_q] <= bus.dec_pred_pc;
               tail_q            <= tail_q + ID_ONE;
            end
         end
      end
   end

   assign bus.rob_full         = full_q;
   assign bus.rob_tail_id      = tail_q;
   assign bus.rob_head_id      = head_q;
   assign bus.rob_ready        = commit_rdy_q;
   assign bus.rob_rd           = commit_rd_q;
   assign bus.rob_val          = commit_val_q;
   assign bus.rob_store_commit = store_commit_q;
   assign bus.rob_flush        = flush_q;
   assign bus.rob_flush_pc     = flush_pc_q;
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: issue, writeback, in-order commit, full, flush, store, bypass, reset.
module tb_reorder_buffer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   reorder_buffer_if #(.ROB_SIZE_WIDTH(3), .XLEN(32), .REG_CNT_WIDTH(5)) bus ();

   reorder_buffer #(.ROB_SIZE_WIDTH(3), .XLEN(32), .REG_CNT_WIDTH(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.stall = 1'b0; bus.dec_ready = 1'b0; bus.dec_kind = 2'd0; bus.dec_rd = '0; bus.dec_pred_pc = '0;
      bus.alu_ready = 1'b0; bus.alu_rob_id = '0; bus.alu_val = '0; bus.alu_next_pc = '0;
      bus.lsb_ready = 1'b0; bus.lsb_rob_id = '0; bus.lsb_val = '0;
      bus.q1_id = '0; bus.q2_id = '0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1'b1;
      cyc();
      cyc();
      rst = 1'b0;
   endtask

   task automatic issue(input logic [1:0] kind, input logic [4:0] rd, input logic [31:0] pc);
      bus.dec_kind = kind; bus.dec_rd = rd; bus.dec_pred_pc = pc; bus.dec_ready = 1'b1;
      cyc();
      bus.dec_ready = 1'b0;
   endtask

   task automatic alu_set(input logic [2:0] id, input logic [31:0] val, input logic [31:0] npc);
      bus.alu_ready = 1'b1; bus.alu_rob_id = id; bus.alu_val = val; bus.alu_next_pc = npc;
   endtask

   initial begin
      clear_inputs();

      // Reset state
      do_reset();
      check("rst_full",   32'(bus.rob_full), 32'd0);
      check("rst_ready",  32'(bus.rob_ready), 32'd0);
      check("rst_flush",  32'(bus.rob_flush), 32'd0);
      check("rst_store",  32'(bus.rob_store_commit), 32'd0);
      check("rst_head",   32'(bus.rob_head_id), 32'd0);
      check("rst_tail",   32'(bus.rob_tail_id), 32'd0);
      check("rst_rd",     32'(bus.rob_rd), 32'd0);
      check("rst_val",    bus.rob_val, 32'd0);

      // Single reg-write: issue, ALU writeback with query bypass, commit
      issue(2'd0, 5'd5, 32'h0);
      check("t1_tail", 32'(bus.rob_tail_id), 32'd1);
      bus.q1_id = 3'd0; bus.q2_id = 3'd3;
      #1;
      check("t1_q1_notready", 32'(bus.q1_ready), 32'd0);
      alu_set(3'd0, 32'h1234, 32'h0);
      #1;
      check("t1_q1_bypass_rdy", 32'(bus.q1_ready), 32'd1);
      check("t1_q1_bypass_val", bus.q1_val, 32'h1234);
      check("t1_q2_idle", 32'(bus.q2_ready), 32'd0);
      cyc();
      bus.alu_ready = 1'b0;
      #1;
      check("t1_no_early_commit", 32'(bus.rob_ready), 32'd0);
      check("t1_q1_stored_rdy", 32'(bus.q1_ready), 32'd1);
      check("t1_q1_stored_val", bus.q1_val, 32'h1234);
      cyc();
      check("t1_commit_ready", 32'(bus.rob_ready), 32'd1);
      check("t1_commit_rd",    32'(bus.rob_rd), 32'd5);
      check("t1_commit_val",   bus.rob_val, 32'h1234);
      check("t1_head",         32'(bus.rob_head_id), 32'd1);
      cyc();
      check("t1_pulse_end", 32'(bus.rob_ready), 32'd0);

      // Fill all 8 entries, 9th issue ignored, commit frees a slot one cycle later
      do_reset();
      bus.dec_ready = 1'b1; bus.dec_kind = 2'd0;
      for (int i = 0; i < 8; i++) begin
         bus.dec_rd = 5'(i + 1);
         cyc();
      end
      check("t2_full", 32'(bus.rob_full), 32'd1);
      check("t2_tail_wrap", 32'(bus.rob_tail_id), 32'd0);
      bus.dec_rd = 5'd9;
      cyc();
      check("t2_ninth_tail", 32'(bus.rob_tail_id), 32'd0);
      check("t2_ninth_full", 32'(bus.rob_full), 32'd1);
      alu_set(3'd0, 32'hAA, 32'h0);
      cyc();
      bus.alu_ready = 1'b0;
      cyc();
      check("t2_commit_ready", 32'(bus.rob_ready), 32'd1);
      check("t2_commit_rd",    32'(bus.rob_rd), 32'd1);
      check("t2_commit_val",   bus.rob_val, 32'hAA);
      check("t2_full_clear",   32'(bus.rob_full), 32'd0);
      check("t2_no_issue_on_commit", 32'(bus.rob_tail_id), 32'd0);
      cyc();
      check("t2_refill_tail", 32'(bus.rob_tail_id), 32'd1);
      check("t2_refill_full", 32'(bus.rob_full), 32'd1);
      bus.dec_ready = 1'b0;

      // Out-of-order writebacks commit in order; LSB beats ALU on the same id
      do_reset();
      issue(2'd0, 5'd1, 32'h0);
      issue(2'd0, 5'd2, 32'h0);
      issue(2'd0, 5'd3, 32'h0);
      alu_set(3'd2, 32'hBAD, 32'h0);
      bus.lsb_ready = 1'b1; bus.lsb_rob_id = 3'd2; bus.lsb_val = 32'h22;
      bus.q1_id = 3'd2;
      #1;
      check("t3_q1_lsb_wins", bus.q1_val, 32'h22);
      cyc();
      bus.lsb_ready = 1'b0;
      alu_set(3'd1, 32'h11, 32'h0);
      cyc();
      alu_set(3'd0, 32'h10, 32'h0);
      cyc();
      bus.alu_ready = 1'b0;
      check("t3_wait", 32'(bus.rob_ready), 32'd0);
      cyc();
      check("t3_c0_rd",  32'(bus.rob_rd), 32'd1);
      check("t3_c0_val", bus.rob_val, 32'h10);
      check("t3_c0_head", 32'(bus.rob_head_id), 32'd1);
      cyc();
      check("t3_c1_rd",  32'(bus.rob_rd), 32'd2);
      check("t3_c1_val", bus.rob_val, 32'h11);
      cyc();
      check("t3_c2_rdy", 32'(bus.rob_ready), 32'd1);
      check("t3_c2_rd",  32'(bus.rob_rd), 32'd3);
      check("t3_c2_val", bus.rob_val, 32'h22);
      check("t3_c2_head", 32'(bus.rob_head_id), 32'd3);

      // Branch mispredict flushes and drops younger work
      do_reset();
      issue(2'd1, 5'd0, 32'h100);
      issue(2'd0, 5'd7, 32'h0);
      alu_set(3'd1, 32'h77, 32'h0);
      cyc();
      alu_set(3'd0, 32'h0, 32'h200);
      cyc();
      bus.alu_ready = 1'b0;
      check("t4_tail_before", 32'(bus.rob_tail_id), 32'd2);
      bus.dec_ready = 1'b1; bus.dec_kind = 2'd0; bus.dec_rd = 5'd9;
      cyc();
      check("t4_flush",    32'(bus.rob_flush), 32'd1);
      check("t4_flush_pc", bus.rob_flush_pc, 32'h200);
      check("t4_head",     32'(bus.rob_head_id), 32'd0);
      check("t4_tail",     32'(bus.rob_tail_id), 32'd0);
      check("t4_full",     32'(bus.rob_full), 32'd0);
      check("t4_no_ready", 32'(bus.rob_ready), 32'd0);
      cyc();
      check("t4_flush_end", 32'(bus.rob_flush), 32'd0);
      check("t4_issue_blocked", 32'(bus.rob_tail_id), 32'd0);
      bus.dec_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc();
         check("t4_young_never", 32'(bus.rob_ready), 32'd0);
      end

      // Stall blocks issue; store commits via LSB
      do_reset();
      bus.stall = 1'b1; bus.dec_ready = 1'b1;
      cyc();
      check("t5_stall_tail", 32'(bus.rob_tail_id), 32'd0);
      bus.stall = 1'b0; bus.dec_ready = 1'b0;
      issue(2'd2, 5'd3, 32'h0);
      bus.lsb_ready = 1'b1; bus.lsb_rob_id = 3'd0; bus.lsb_val = 32'h40;
      cyc();
      bus.lsb_ready = 1'b0;
      cyc();
      check("t5_store_commit", 32'(bus.rob_store_commit), 32'd1);
      check("t5_no_ready",     32'(bus.rob_ready), 32'd0);
      check("t5_rd_zero",      32'(bus.rob_rd), 32'd0);
      check("t5_head",         32'(bus.rob_head_id), 32'd1);
      cyc();
      check("t5_store_end", 32'(bus.rob_store_commit), 32'd0);

      // Reset wins over a pending commit and over a pending flush
      do_reset();
      issue(2'd0, 5'd4, 32'h0);
      alu_set(3'd0, 32'h55, 32'h0);
      cyc();
      bus.alu_ready = 1'b0;
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      check("t6_rst_ready", 32'(bus.rob_ready), 32'd0);
      check("t6_rst_val",   bus.rob_val, 32'd0);
      check("t6_rst_head",  32'(bus.rob_head_id), 32'd0);
      check("t6_rst_tail",  32'(bus.rob_tail_id), 32'd0);
      issue(2'd1, 5'd0, 32'h100);
      alu_set(3'd0, 32'h0, 32'h300);
      cyc();
      bus.alu_ready = 1'b0;
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      check("t6_rst_flush",    32'(bus.rob_flush), 32'd0);
      check("t6_rst_flush_pc", bus.rob_flush_pc, 32'd0);
      check("t6_rst_tail2",    32'(bus.rob_tail_id), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
